// File: rtl/neuron_pkg.sv
// -----------------------------------------------------------------------------
// neuron_pkg
// Shared FP32 definitions for the neuron datapath (potential adder, spike
// generator, reset unit): field positions, the all-ones exponent code, the
// fp32_t type and a NaN predicate.
// -----------------------------------------------------------------------------
package neuron_pkg;

  typedef logic [31:0] fp32_t;

  localparam int FP32_SIGN_BIT = 31;
  localparam int FP32_EXP_MSB  = 30;
  localparam int FP32_EXP_LSB  = 23;
  localparam int FP32_MAN_MSB  = 22;

  localparam logic [7:0] FP32_EXP_ALL_ONES = 8'hFF;

  // NaN: exponent all ones with a non-zero mantissa (infinity has mantissa 0).
  function automatic logic fp32_is_nan(input fp32_t x);
    return (x[FP32_EXP_MSB:FP32_EXP_LSB] == FP32_EXP_ALL_ONES) &&
           (x[FP32_MAN_MSB:0] != '0);
  endfunction

endpackage

// File: rtl/fp32_ge.sv
// -----------------------------------------------------------------------------
// fp32_ge
// Combinational IEEE-754 single-precision "a >= b" comparator.
//   a, b       : FP32 operands
//   ge         : 1 when a >= b under FP32 ordering (+0 == -0, infinities
//                ordered normally); 0 whenever the pair is unordered
//   unordered  : 1 when either operand is NaN
// -----------------------------------------------------------------------------
module fp32_ge
  import neuron_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output logic  ge,
  output logic  unordered
);

  logic        a_sign, b_sign;
  logic [30:0] a_mag,  b_mag;

  assign a_sign = a[FP32_SIGN_BIT];
  assign b_sign = b[FP32_SIGN_BIT];
  assign a_mag  = a[FP32_SIGN_BIT-1:0];
  assign b_mag  = b[FP32_SIGN_BIT-1:0];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if-chain can leave it unassigned and infer a latch.
  always_comb begin
    ge        = 1'b0;
    unordered = fp32_is_nan(a) || fp32_is_nan(b);
    if (unordered) begin
      ge = 1'b0;
    end else if ((a_mag == '0) && (b_mag == '0)) begin
      ge = 1'b1;                 // +0 / -0 in any combination compare equal
    end else if (a_sign != b_sign) begin
      ge = b_sign;               // the non-negative operand is the larger one
    end else if (!a_sign) begin
      ge = (a_mag >= b_mag);
    end else begin
      ge = (a_mag <= b_mag);     // both negative: smaller magnitude is larger
    end
  end

endmodule

// File: rtl/spike_generator.sv
// -----------------------------------------------------------------------------
// spike_generator
// Threshold-and-fire stage between the potential adder and the neuron reset
// unit. One time-multiplexed neuron sample is accepted per handshake, compared
// against its threshold, gated by a per-neuron refractory counter and
// presented one cycle later through a single output register.
//
// Ports:
//   CLK, RESET               clock (rising edge), async active-low reset
//   in_valid / in_ready      input handshake; in_ready = !out_valid || out_ready
//   in_neuron_id             neuron index of the sample
//   adder_potential          FP32 accumulated membrane potential
//   v_threshold              FP32 firing threshold
//   refractory_period        samples to suppress after a spike (0 = none)
//   out_valid / out_ready    output handshake
//   out_neuron_id            index of the registered result
//   potential_out            potential passed through unchanged
//   v_threshold_out          threshold passed through unchanged
//   spiked                   neuron fired
//   spike_count              saturating count of spikes since reset
//
// Build option: define SPIKE_GEN_REFRACTORY_EN to implement the per-neuron
// refractory counters; without it the spike is purely the fire condition and
// refractory_period is ignored. Handshake and latency are the same either way.
// -----------------------------------------------------------------------------
module spike_generator
  import neuron_pkg::*;
#(
  parameter int NEURONS   = 16,
  parameter int ID_W      = 4,
  parameter int REFRACT_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ID_W-1:0]      in_neuron_id,
  input  logic [31:0]          adder_potential,
  input  logic [31:0]          v_threshold,
  input  logic [REFRACT_W-1:0] refractory_period,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ID_W-1:0]      out_neuron_id,
  output logic [31:0]          potential_out,
  output logic [31:0]          v_threshold_out,
  output logic                 spiked,
  output logic [CNT_W-1:0]     spike_count
);

  logic             out_valid_q, out_valid_d;
  logic [ID_W-1:0]  out_id_q,    out_id_d;
  fp32_t            pot_q,       pot_d;
  fp32_t            thr_q,       thr_d;
  logic             spiked_q,    spiked_d;
  logic [CNT_W-1:0] count_q,     count_d;

  logic accept;
  logic id_ok;
  logic cmp_ge, cmp_unordered;
  logic fire;

  fp32_ge u_cmp (
    .a         (adder_potential),
    .b         (v_threshold),
    .ge        (cmp_ge),
    .unordered (cmp_unordered)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // Out-of-range indices pass through without firing or touching any counter.
  assign id_ok    = 32'(in_neuron_id) < 32'(NEURONS);

`ifdef SPIKE_GEN_REFRACTORY_EN
  logic [REFRACT_W-1:0] rc_q [NEURONS];
  logic [REFRACT_W-1:0] rc_d [NEURONS];
  logic [REFRACT_W-1:0] rc_cur;

  always_comb begin
    rc_cur = '0;
    for (int i = 0; i < NEURONS; i++) begin
      if (in_neuron_id == ID_W'(i)) rc_cur = rc_q[i];
    end
  end

  // A refractory neuron never fires, whatever the compare says.
  assign fire = cmp_ge && !cmp_unordered && id_ok && (rc_cur == '0);

  // Counters advance only on an accepted sample of their own neuron.
  always_comb begin
    for (int i = 0; i < NEURONS; i++) begin
      rc_d[i] = rc_q[i];
      if (accept && id_ok && (in_neuron_id == ID_W'(i))) begin
        if (rc_q[i] != '0) rc_d[i] = rc_q[i] - 1'b1;
        else if (fire)     rc_d[i] = refractory_period;
      end
    end
  end

  // NOTE: the counter array is built from flops rather than a RAM because an
  // asynchronous reset must clear every entry at once.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NEURONS; i++) rc_q[i] <= '0;
    end else begin
      for (int i = 0; i < NEURONS; i++) rc_q[i] <= rc_d[i];
    end
  end
`else
  logic unused_refractory;
  assign unused_refractory = ^refractory_period;
  assign fire = cmp_ge && !cmp_unordered && id_ok;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    pot_d       = pot_q;
    thr_d       = thr_q;
    spiked_d    = spiked_q;
    count_d     = count_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_id_d    = in_neuron_id;
      pot_d       = adder_potential;
      thr_d       = v_threshold;
      spiked_d    = fire;
      if (fire && (count_q != '1)) count_d = count_q + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge; blocking '=' is kept to the
  // combinational blocks above.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      pot_q       <= '0;
      thr_q       <= '0;
      spiked_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      pot_q       <= pot_d;
      thr_q       <= thr_d;
      spiked_q    <= spiked_d;
      count_q     <= count_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_neuron_id   = out_id_q;
  assign potential_out   = pot_q;
  assign v_threshold_out = thr_q;
  assign spiked          = spiked_q;
  assign spike_count     = count_q;

endmodule

// File: tb/tb_spike_generator.sv
// -----------------------------------------------------------------------------
// tb_spike_generator
// Self-checking bench for spike_generator. A behavioural model maps each FP32
// value to a signed ordering key (NaN excluded), tracks per-neuron refractory
// counts in a plain integer array and keeps a saturating spike total. The
// spike counter is narrowed to 6 bits so saturation is reached in the run.
// -----------------------------------------------------------------------------
module tb_spike_generator;

  localparam int NEURONS = 16;
  localparam int ID_W    = 4;
  localparam int RW      = 4;
  localparam int CW      = 6;
  localparam int MAXC    = (1 << CW) - 1;
`ifdef SPIKE_GEN_REFRACTORY_EN
  localparam bit REFR = 1'b1;
`else
  localparam bit REFR = 1'b0;
`endif

  localparam logic [31:0] F15_5 = 32'h41780000;
  localparam logic [31:0] F15_0 = 32'h41700000;
  localparam logic [31:0] F16_0 = 32'h41800000;
  localparam logic [31:0] FM1_0 = 32'hBF800000;
  localparam logic [31:0] FPZ   = 32'h00000000;
  localparam logic [31:0] FNZ   = 32'h80000000;
  localparam logic [31:0] FNAN  = 32'h7FC00000;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            in_valid;
  logic            in_ready;
  logic [ID_W-1:0] in_neuron_id;
  logic [31:0]     adder_potential;
  logic [31:0]     v_threshold;
  logic [RW-1:0]   refractory_period;
  logic            out_valid;
  logic            out_ready;
  logic [ID_W-1:0] out_neuron_id;
  logic [31:0]     potential_out;
  logic [31:0]     v_threshold_out;
  logic            spiked;
  logic [CW-1:0]   spike_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int m_rc [NEURONS];
  int m_count;
  bit exp_spk;
  bit last_ready;

  always #5 CLK = ~CLK;

  spike_generator #(
    .NEURONS(NEURONS), .ID_W(ID_W), .REFRACT_W(RW), .CNT_W(CW)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_neuron_id      (in_neuron_id),
    .adder_potential   (adder_potential),
    .v_threshold       (v_threshold),
    .refractory_period (refractory_period),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_neuron_id     (out_neuron_id),
    .potential_out     (potential_out),
    .v_threshold_out   (v_threshold_out),
    .spiked            (spiked),
    .spike_count       (spike_count)
  );

  // ---------------- reference model ----------------
  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Monotonic key: magnitude for positives, negated magnitude for negatives,
  // so both zeros land on 0 and infinities sit beyond every finite value.
  function automatic longint fkey(input logic [31:0] x);
    longint mag;
    mag = longint'(x[30:0]);
    return x[31] ? -mag : mag;
  endfunction

  function automatic bit model_fire(input logic [31:0] pot, input logic [31:0] thr);
    if (is_nan(pot) || is_nan(thr)) return 1'b0;
    return fkey(pot) >= fkey(thr);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NEURONS; i++) m_rc[i] = 0;
    m_count = 0;
  endfunction

  function automatic bit model_step(input int id, input logic [31:0] pot,
                                    input logic [31:0] thr, input int per);
    bit f;
    f = model_fire(pot, thr);
    if (id >= NEURONS) return 1'b0;
    if (REFR) begin
      if (m_rc[id] != 0) begin
        m_rc[id] = m_rc[id] - 1;
        f = 1'b0;
      end else if (f) begin
        m_rc[id] = per;
      end
    end
    if (f && m_count < MAXC) m_count = m_count + 1;
    return f;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0: v = FPZ;
      1: v = FNZ;
      2: v = {1'b0, 8'hFF, 23'($urandom_range(1, 8388607))};
      3: v = 32'h7F800000;
      4: v = 32'hFF800000;
      default: v = {1'($urandom_range(0, 3) == 0), 8'(126 + $urandom_range(0, 3)),
                    23'($urandom_range(0, 3) << 20)};
    endcase
    return v;
  endfunction

  // One sample, out_ready held high; model updated at the accepting edge.
  task automatic drive(input logic [ID_W-1:0] id, input logic [31:0] pot,
                       input logic [31:0] thr, input logic [RW-1:0] per);
    @(negedge CLK);
    in_valid = 1'b1; in_neuron_id = id; adder_potential = pot;
    v_threshold = thr; refractory_period = per; out_ready = 1'b1;
    #1 last_ready = in_ready;
    @(posedge CLK);
    exp_spk = model_step(int'(id), pot, thr, int'(per));
    #1 in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_neuron_id = '0;
    adder_potential = '0; v_threshold = '0; refractory_period = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    total_cnt++;
    if ({out_valid, spiked, spike_count, out_neuron_id, potential_out, v_threshold_out} !== '0)
      $display("FAIL reset_outputs: valid=%0b spk=%0b cnt=%0d id=%0d pot=%h thr=%h, required all 0",
               out_valid, spiked, spike_count, out_neuron_id, potential_out, v_threshold_out);
    else pass_cnt++;
    @(negedge CLK) RESET = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_fire_basic();
    logic [31:0] pots [5] = '{F15_5, F15_0, FM1_0, FNAN, FNZ};
    logic [31:0] thrs [5] = '{F15_5, F15_5, FNZ,   FPZ,  FPZ};
    for (int i = 0; i < 5; i++) begin
      drive(ID_W'(i), pots[i], thrs[i], '0);
      total_cnt++;
      if (out_valid !== 1'b1 || spiked !== exp_spk || spike_count !== CW'(m_count) ||
          out_neuron_id !== ID_W'(i) || potential_out !== pots[i] || v_threshold_out !== thrs[i])
        $display("FAIL fire_basic[%0d]: valid=%0b spk=%0b cnt=%0d id=%0d pot=%h thr=%h, required 1 %0b %0d %0d %h %h",
                 i, out_valid, spiked, spike_count, out_neuron_id, potential_out, v_threshold_out,
                 exp_spk, m_count, i, pots[i], thrs[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_refractory();
    for (int i = 0; i < 5; i++) begin
      drive(4'd3, F16_0, F15_5, 4'd2);
      total_cnt++;
      if (last_ready !== 1'b1 || spiked !== exp_spk || spike_count !== CW'(m_count))
        $display("FAIL refractory[%0d]: rdy=%0b spk=%0b cnt=%0d, required 1 %0b %0d",
                 i, last_ready, spiked, spike_count, exp_spk, m_count);
      else pass_cnt++;
    end
  endtask

  task automatic test_interleave();
    for (int i = 0; i < 8; i++) begin
      drive(ID_W'(3 + (i % 2)), F16_0, F15_5, 4'd2);
      total_cnt++;
      if (spiked !== exp_spk || out_neuron_id !== ID_W'(3 + (i % 2)) || spike_count !== CW'(m_count))
        $display("FAIL interleave[%0d]: spk=%0b id=%0d cnt=%0d, required %0b %0d %0d",
                 i, spiked, out_neuron_id, spike_count, exp_spk, 3 + (i % 2), m_count);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back_backpressure();
    bit spk_a, spk_b;
    drive(4'd5, F16_0, F15_5, 4'd0);
    spk_a = exp_spk;
    in_valid = 1'b1; in_neuron_id = 4'd6; adder_potential = F15_5;
    v_threshold = F15_5; refractory_period = 4'd1; out_ready = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL bp_ready_low: got %0b, required 0", in_ready);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      total_cnt++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_neuron_id !== 4'd5 ||
          potential_out !== F16_0 || v_threshold_out !== F15_5 || spiked !== spk_a ||
          spike_count !== CW'(m_count))
        $display("FAIL bp_hold[%0d]: rdy=%0b valid=%0b id=%0d pot=%h thr=%h spk=%0b cnt=%0d, required 0 1 5 %h %h %0b %0d",
                 c, in_ready, out_valid, out_neuron_id, potential_out, v_threshold_out, spiked,
                 spike_count, F16_0, F15_5, spk_a, m_count);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    @(posedge CLK);
    spk_b = model_step(6, F15_5, F15_5, 1);
    #1 in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || out_neuron_id !== 4'd6 || spiked !== spk_b || spike_count !== CW'(m_count))
      $display("FAIL bp_release: valid=%0b id=%0d spk=%0b cnt=%0d, required 1 6 %0b %0d",
               out_valid, out_neuron_id, spiked, spike_count, spk_b, m_count);
    else pass_cnt++;
    @(posedge CLK); #1;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL bp_no_duplicate: valid=%0b, required 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do begin
      drive(4'd3, F16_0, F15_5, 4'd3);
      n++;
    end while (REFR && m_rc[3] == 0 && n < 8);
    #2 RESET = 1'b0;
    #1;
    model_reset();
    total_cnt++;
    if ({out_valid, spiked, spike_count, out_neuron_id, potential_out, v_threshold_out} !== '0)
      $display("FAIL reset_mid_outputs: valid=%0b spk=%0b cnt=%0d id=%0d pot=%h thr=%h, required all 0",
               out_valid, spiked, spike_count, out_neuron_id, potential_out, v_threshold_out);
    else pass_cnt++;
    @(negedge CLK) RESET = 1'b1;
    drive(4'd3, F16_0, F15_5, 4'd2);
    total_cnt++;
    if (spiked !== 1'b1 || exp_spk !== 1'b1 || spike_count !== CW'(1))
      $display("FAIL reset_mid_refire: spk=%0b cnt=%0d, required 1 1", spiked, spike_count);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] p, t;
    logic [ID_W-1:0] id;
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      id = ID_W'($urandom_range(0, NEURONS - 1));
      p  = rand_fp();
      t  = ($urandom_range(0, 5) == 0) ? p : rand_fp();
      drive(id, p, t, RW'($urandom_range(0, 3)));
      total_cnt++;
      if (spiked !== exp_spk || spike_count !== CW'(m_count) || out_neuron_id !== id ||
          potential_out !== p || v_threshold_out !== t || out_valid !== 1'b1) begin
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d]: id=%0d pot=%h thr=%h spk=%0b cnt=%0d, required %0d %h %h %0b %0d",
                   i, out_neuron_id, potential_out, v_threshold_out, spiked, spike_count,
                   id, p, t, exp_spk, m_count);
      end else pass_cnt++;
      if ($urandom_range(0, 4) == 0) @(posedge CLK);
    end
    total_cnt++;
    if (spike_count !== CW'(MAXC) && m_count == MAXC)
      $display("FAIL saturation: cnt=%0d, required %0d", spike_count, MAXC);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fire_basic();
    test_refractory();
    test_interleave();
    test_back_to_back_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spike_generator.md
# spike_generator

Threshold-and-fire stage that produces the `spiked` flag and the threshold-qualified potential consumed by the neuron reset unit. It accepts one time-multiplexed neuron sample per handshake (IEEE-754 single-precision membrane potential after accumulation) and compares it against `v_threshold`. It enforces a per-neuron refractory window and presents the result, registered, to the downstream reset/write-back path. It sits between the potential adder and the reset unit in the neuron datapath.

## Interface
- `NEURONS`, 16: number of time-multiplexed neurons tracked.
- `ID_W`, 4: neuron index width; `NEURONS` ≤ 2^`ID_W`.
- `REFRACT_W`, 4: refractory counter width.
- `CNT_W`, 16: spike event counter width.
- `CLK` input 1: single clock, rising edge.
- `RESET` input 1: asynchronous, active-low reset.
- `in_valid` input 1: sample present.
- `in_ready` output 1: sample accepted when `in_valid && in_ready`.
- `in_neuron_id` input ID_W: neuron index of sample.
- `adder_potential` input 32: FP32 accumulated potential.
- `v_threshold` input 32: FP32 threshold, sampled with the sample.
- `refractory_period` input REFRACT_W: samples to suppress after a spike.
- `out_valid` output 1: result present.
- `out_ready` input 1: downstream accepts result.
- `out_neuron_id` output ID_W: index of result.
- `potential_out` output 32: potential passed through unchanged.
- `v_threshold_out` output 32: threshold passed through.
- `spiked` output 1: neuron fired.
- `spike_count` output CNT_W: saturating total spikes since reset.

## Operation
- Fire condition: `adder_potential >= v_threshold` under FP32 ordering. Sign/magnitude compare. +0 equals −0. Any NaN operand means no fire. Infinities are ordered normally.
- Refractory: per-neuron counter `rc[id]`.
  - When a sample is accepted with `rc[id] != 0`: `spiked`=0 regardless of compare, and `rc[id]` decrements by 1.
  - When a sample is accepted with `rc[id] == 0` and the fire condition holds: `spiked`=1 and `rc[id]` loads `refractory_period`.
  - Period 0 means no suppression.
- Counters advance per accepted sample of that neuron, not per clock.
- `spike_count` increments on each accepted sample producing `spiked`=1 and holds at all-ones.
- `in_neuron_id` ≥ `NEURONS`: sample passes with `spiked`=0; no counter is touched.

## Timing
- Single register stage. The result appears on `out_*` the cycle after acceptance, so latency is 1.
- `in_ready = !out_valid || out_ready`. This gives full throughput of one sample per cycle when downstream is ready.
- `out_*` hold stable while `out_valid && !out_ready`.
- Back-to-back samples of the same neuron: the second sample sees the `rc` value updated by the first. `rc` is read and written in the acceptance cycle, so no hazard exists.
- Reset (asynchronous, mid-operation included):
  - `out_valid`=0, `spiked`=0, `spike_count`=0, `out_neuron_id`=0, `potential_out`=0, `v_threshold_out`=0.
  - All `rc`=0.
  - An in-flight result is discarded.
- `spike_count` is updated in the same edge that registers the result.

## Configuration
- `SPIKE_GEN_REFRACTORY_EN`:
  - Defined: refractory counters are implemented as above.
  - Undefined: no counter storage. `spiked` is purely the fire condition, and `refractory_period` is ignored.
  - Handshake and latency are identical in both builds.

## Structure
- Shared package `neuron_pkg`:
  - FP32 field constants: sign bit 31, exponent [30:23], mantissa [22:0], exponent all-ones.
  - NaN predicate constant and typedef `fp32_t`, reused by the adder and the reset unit.
- One combinational sub-module `fp32_ge` (a, b → ge, unordered). It is instantiated once; the parent owns the pipeline, the `rc` array and the counter.

## Test plan
- 15.5 (0x41780000) vs threshold 15.5, period 0 → `spiked`=1 one cycle later; `spike_count`=1.
- 15.0 (0x41700000) vs 15.5; then −1.0 (0xBF800000) vs −0.0; then NaN (0x7FC00000) vs 0 → `spiked`=0, 0, 0. Separately, 0x80000000 vs 0x00000000 → `spiked`=1.
- Neuron 3, period 2, five consecutive samples of 16.0 (0x41800000) vs 15.5 → `spiked` 1, 0, 0, 1, 0.
- Interleave neuron 3 at 16.0 with neuron 4 at 16.0, both period 2 → each neuron's refractory window is tracked independently.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, `out_*` stable, no sample lost or duplicated on release.
- Assert `RESET` low while `out_valid`=1 and neuron 3 is refractory → outputs return to reset values; next 16.0 sample for neuron 3 → `spiked`=1.
